// File: rtl/audio_ctrl_pkg.sv
// rtl/audio_ctrl_pkg.sv - shared types and defaults for the audio record/playback controller
//
// Purpose : recorder FSM state encoding and default parameter values.
// Ports   : none (package).

package audio_ctrl_pkg;

  localparam int ADDR_W_DEFAULT    = 16;
  localparam int DB_CYCLES_DEFAULT = 100000;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RECORD = 2'd1,
    PLAY   = 2'd2
  } state_e;

endpackage

// File: rtl/button_debounce.sv
// rtl/button_debounce.sv - push-button debouncer producing one pulse per accepted press
//
// Purpose : counts consecutive high samples of a synchronized button and emits
//           a single-cycle pulse when the count reaches DB_CYCLES.
// Ports   : clk_i    - clock
//           resetn_i - synchronous active-low reset
//           btn_i    - synchronized button level
//           press_o  - one-cycle pulse, combinational, on the accepting clock

module button_debounce
  import audio_ctrl_pkg::*;
#(
  parameter int DB_CYCLES = DB_CYCLES_DEFAULT
) (
  input  logic clk_i,
  input  logic resetn_i,
  input  logic btn_i,
  output logic press_o
);

  localparam int CNT_W = $clog2(DB_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX    = CNT_W'(DB_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ACCEPT = CNT_W'(DB_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pressed_q, pressed_d;

  // The pulse fires on the clock that sees the DB_CYCLES-th consecutive high
  // sample, so the consumer acts on that same edge. The counter saturates and
  // pressed_q blocks repeats until the button is released.
  always_comb begin
    cnt_d     = cnt_q;
    pressed_d = pressed_q;
    press_o   = 1'b0;
    if (!btn_i) begin
      cnt_d     = '0;
      pressed_d = 1'b0;
    end else begin
      if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_ONE;
      if (cnt_q == CNT_ACCEPT && !pressed_q && resetn_i) begin
        press_o   = 1'b1;
        pressed_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!resetn_i) begin
      cnt_q     <= '0;
      pressed_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      pressed_q <= pressed_d;
    end
  end

endmodule

// File: rtl/audio_rec_ctrl.sv
// rtl/audio_rec_ctrl.sv - record/playback controller sequencing a sample memory
//
// Purpose : IDLE/RECORD/PLAY state machine driven by debounced record/play
//           buttons; steps the sample-memory address on each sample_tick.
// Ports   : clock       - clock
//           reset       - synchronous active-low reset
//           rec_btn     - record button (synchronized)
//           play_btn    - play button (synchronized)
//           sample_tick - one-cycle strobe at the sample rate
//           mem_addr    - sample-memory address
//           mem_we      - sample-memory write enable
//           play_en     - audio output stage enable
//           rec_active  - high while recording
//           play_active - high while playing
//           rec_len     - length of the last recording in samples

module audio_rec_ctrl
  import audio_ctrl_pkg::*;
#(
  parameter int ADDR_W    = ADDR_W_DEFAULT,
  parameter int DB_CYCLES = DB_CYCLES_DEFAULT
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              rec_btn,
  input  logic              play_btn,
  input  logic              sample_tick,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic              play_en,
  output logic              rec_active,
  output logic              play_active,
  output logic [ADDR_W:0]   rec_len
);

  localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] ADDR_LAST = {ADDR_W{1'b1}};
  localparam logic [ADDR_W:0]   LEN_ONE   = (ADDR_W + 1)'(1);

  state_e            state_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [ADDR_W:0]   rec_len_q;
  logic              rec_active_q;
  logic              play_active_q;

  logic rec_press;
  logic play_press;
  logic play_last;

  button_debounce #(.DB_CYCLES(DB_CYCLES)) u_rec_db (
    .clk_i    (clock),
    .resetn_i (reset),
    .btn_i    (rec_btn),
    .press_o  (rec_press)
  );

  button_debounce #(.DB_CYCLES(DB_CYCLES)) u_play_db (
    .clk_i    (clock),
    .resetn_i (reset),
    .btn_i    (play_btn),
    .press_o  (play_press)
  );

  // Last sample of the stored clip; rec_len is never zero while in PLAY.
  assign play_last = ({1'b0, mem_addr_q} == (rec_len_q - LEN_ONE));

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q       <= IDLE;
      mem_addr_q    <= '0;
      rec_len_q     <= '0;
      rec_active_q  <= 1'b0;
      play_active_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          // Record has priority over a simultaneous play press.
          if (rec_press) begin
            state_q      <= RECORD;
            mem_addr_q   <= '0;
            rec_len_q    <= '0;
            rec_active_q <= 1'b1;
          end else if (play_press && rec_len_q != '0) begin
            state_q       <= PLAY;
            mem_addr_q    <= '0;
            play_active_q <= 1'b1;
          end
        end
        RECORD: begin
          // A tick coinciding with a stop press is still written and counted.
          if (sample_tick) rec_len_q <= rec_len_q + LEN_ONE;
          if ((sample_tick && mem_addr_q == ADDR_LAST) || rec_press) begin
            state_q      <= IDLE;
            mem_addr_q   <= '0;
            rec_active_q <= 1'b0;
          end else if (sample_tick) begin
            mem_addr_q <= mem_addr_q + ADDR_ONE;
          end
        end
        PLAY: begin
          if (play_press || (sample_tick && play_last)) begin
            state_q       <= IDLE;
            mem_addr_q    <= '0;
            play_active_q <= 1'b0;
          end else if (sample_tick) begin
            mem_addr_q <= mem_addr_q + ADDR_ONE;
          end
        end
        default: begin
          state_q       <= IDLE;
          mem_addr_q    <= '0;
          rec_active_q  <= 1'b0;
          play_active_q <= 1'b0;
        end
      endcase
    end
  end

  // Status outputs are forced low while reset is held, before the edge clears them.
  assign mem_we      = reset & sample_tick & (state_q == RECORD);
  assign rec_active  = reset & rec_active_q;
  assign play_active = reset & play_active_q;
  assign play_en     = reset & play_active_q;
  assign mem_addr    = mem_addr_q;
  assign rec_len     = rec_len_q;

endmodule

// File: tb/tb_audio_rec_ctrl.sv
// tb/tb_audio_rec_ctrl.sv - self-checking bench for audio_rec_ctrl

module tb_audio_rec_ctrl;

  localparam int AW = 4;
  localparam int DB = 4;

  logic          clock = 1'b0;
  logic          reset;
  logic          rec_btn;
  logic          play_btn;
  logic          sample_tick;
  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic          play_en;
  logic          rec_active;
  logic          play_active;
  logic [AW:0]   rec_len;

  int checks   = 0;
  int failures = 0;
  int mon_err  = 0;

  // Reference model: mode 0 = idle, 1 = recording, 2 = playing.
  int m_mode = 0;
  int m_addr = 0;
  int m_len  = 0;
  int m_rrun = 0;
  int m_prun = 0;
  int dut_wq[$];
  int mdl_wq[$];

  always #5 clock = ~clock;

  audio_rec_ctrl #(.ADDR_W(AW), .DB_CYCLES(DB)) dut (
    .clock       (clock),
    .reset       (reset),
    .rec_btn     (rec_btn),
    .play_btn    (play_btn),
    .sample_tick (sample_tick),
    .mem_addr    (mem_addr),
    .mem_we      (mem_we),
    .play_en     (play_en),
    .rec_active  (rec_active),
    .play_active (play_active),
    .rec_len     (rec_len)
  );

  // One clock: apply inputs, compare outputs with the model, advance the model.
  task automatic cyc(input logic rb, input logic pb, input logic st);
    bit rp, pp, e_rec, e_play, e_we;
    rec_btn = rb; play_btn = pb; sample_tick = st;
    #1;
    e_rec  = reset && (m_mode == 1);
    e_play = reset && (m_mode == 2);
    e_we   = e_rec && st;
    if (mem_we === 1'b1) dut_wq.push_back(int'(mem_addr));
    if (e_we) mdl_wq.push_back(m_addr);
    if (mem_we !== e_we || rec_active !== e_rec || play_active !== e_play ||
        play_en !== e_play || mem_addr !== AW'(m_addr) || rec_len !== (AW+1)'(m_len))
      mon_err++;
    if (!reset) begin
      m_rrun = 0; m_prun = 0; m_mode = 0; m_addr = 0; m_len = 0;
    end else begin
      m_rrun = rb ? m_rrun + 1 : 0;
      m_prun = pb ? m_prun + 1 : 0;
      rp = (m_rrun == DB);
      pp = (m_prun == DB);
      if (m_mode == 0) begin
        if (rp) begin m_mode = 1; m_addr = 0; m_len = 0; end
        else if (pp && m_len > 0) begin m_mode = 2; m_addr = 0; end
      end else if (m_mode == 1) begin
        if (st) m_len = m_len + 1;
        if (rp || (st && m_len == (1 << AW))) begin m_mode = 0; m_addr = 0; end
        else if (st) m_addr = m_addr + 1;
      end else begin
        if (pp) begin m_mode = 0; m_addr = 0; end
        else if (st) begin
          m_addr = m_addr + 1;
          if (m_addr == m_len) begin m_mode = 0; m_addr = 0; end
        end
      end
    end
    @(posedge clock);
    #1;
  endtask

  task automatic press(input logic r, input logic p);
    for (int i = 0; i < DB; i++) cyc(r, p, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      cyc(1'b0, 1'b0, 1'b1);
      repeat ($urandom_range(0, 2)) cyc(1'b0, 1'b0, 1'b0);
    end
  endtask

  task automatic test_reset;
    reset = 1'b0;
    cyc(1'b1, 1'b1, 1'b1);
    cyc(1'b1, 1'b1, 1'b1);
    checks++; if (play_en !== 1'b0) begin failures++; $display("FAIL reset_play_en got=%b exp=0", play_en); end
    reset = 1'b1;
    cyc(1'b0, 1'b0, 1'b0);
    checks++; if (mem_addr !== 4'd0) begin failures++; $display("FAIL reset_mem_addr got=%0d exp=0", mem_addr); end
    checks++; if (rec_len !== 5'd0) begin failures++; $display("FAIL reset_rec_len got=%0d exp=0", rec_len); end
    checks++; if (rec_active !== 1'b0 || play_active !== 1'b0) begin failures++; $display("FAIL reset_active got=%b%b exp=00", rec_active, play_active); end
    checks++; if (mon_err !== 0) begin failures++; $display("FAIL reset_monitor got=%0d exp=0", mon_err); end
  endtask

  task automatic test_bounce;
    repeat (3) cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    repeat (3) cyc(1'b1, 1'b0, 1'b0);
    checks++; if (rec_active !== 1'b0) begin failures++; $display("FAIL bounce_early got=%b exp=0", rec_active); end
    cyc(1'b1, 1'b0, 1'b0);
    checks++; if (rec_active !== 1'b1) begin failures++; $display("FAIL bounce_accept got=%b exp=1", rec_active); end
    repeat (16) cyc(1'b1, 1'b0, 1'b0);
    checks++; if (rec_active !== 1'b1) begin failures++; $display("FAIL bounce_hold got=%b exp=1", rec_active); end
    cyc(1'b0, 1'b0, 1'b0);
    press(1'b1, 1'b0);
    checks++; if (rec_active !== 1'b0) begin failures++; $display("FAIL bounce_stop got=%b exp=0", rec_active); end
  endtask

  task automatic test_record;
    dut_wq.delete();
    press(1'b1, 1'b0);
    ticks(5);
    press(1'b1, 1'b0);
    checks++; if (dut_wq.size() !== 5) begin failures++; $display("FAIL record_writes got=%0d exp=5", dut_wq.size()); end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (i >= dut_wq.size() || dut_wq[i] != i) begin
        failures++; $display("FAIL record_addr[%0d] got=%0d exp=%0d", i, (i < dut_wq.size()) ? dut_wq[i] : -1, i);
      end
    end
    checks++; if (rec_len !== 5'd5) begin failures++; $display("FAIL record_len got=%0d exp=5", rec_len); end
    checks++; if (rec_active !== 1'b0 || mem_addr !== 4'd0) begin failures++; $display("FAIL record_idle got=%b/%0d exp=0/0", rec_active, mem_addr); end
  endtask

  task automatic test_full;
    dut_wq.delete();
    press(1'b1, 1'b0);
    ticks(16);
    ticks(3);
    checks++; if (dut_wq.size() !== 16) begin failures++; $display("FAIL full_writes got=%0d exp=16", dut_wq.size()); end
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (i >= dut_wq.size() || dut_wq[i] != i) begin
        failures++; $display("FAIL full_addr[%0d] got=%0d exp=%0d", i, (i < dut_wq.size()) ? dut_wq[i] : -1, i);
      end
    end
    checks++; if (rec_len !== 5'd16) begin failures++; $display("FAIL full_len got=%0d exp=16", rec_len); end
    checks++; if (rec_active !== 1'b0 || mem_addr !== 4'd0) begin failures++; $display("FAIL full_idle got=%b/%0d exp=0/0", rec_active, mem_addr); end
  endtask

  task automatic test_play;
    press(1'b1, 1'b0);
    ticks(5);
    press(1'b1, 1'b0);
    dut_wq.delete();
    press(1'b0, 1'b1);
    checks++; if (play_en !== 1'b1 || play_active !== 1'b1) begin failures++; $display("FAIL play_start got=%b%b exp=11", play_en, play_active); end
    for (int k = 0; k < 5; k++) begin
      checks++; if (mem_addr !== AW'(k)) begin failures++; $display("FAIL play_addr[%0d] got=%0d exp=%0d", k, mem_addr, k); end
      ticks(1);
    end
    checks++; if (play_active !== 1'b0 || play_en !== 1'b0 || mem_addr !== 4'd0) begin failures++; $display("FAIL play_end got=%b%b/%0d exp=00/0", play_active, play_en, mem_addr); end
    checks++; if (rec_len !== 5'd5) begin failures++; $display("FAIL play_len got=%0d exp=5", rec_len); end
    checks++; if (dut_wq.size() !== 0) begin failures++; $display("FAIL play_writes got=%0d exp=0", dut_wq.size()); end
    reset = 1'b0;
    cyc(1'b0, 1'b0, 1'b0);
    reset = 1'b1;
    press(1'b0, 1'b1);
    checks++; if (play_active !== 1'b0) begin failures++; $display("FAIL play_empty got=%b exp=0", play_active); end
  endtask

  task automatic test_simultaneous;
    press(1'b1, 1'b1);
    checks++; if (rec_active !== 1'b1 || play_active !== 1'b0) begin failures++; $display("FAIL simul_state got=%b%b exp=10", rec_active, play_active); end
    press(1'b1, 1'b0);
    press(1'b1, 1'b0);
    ticks(5);
    press(1'b1, 1'b0);
    press(1'b0, 1'b1);
    ticks(2);
    checks++; if (mem_addr !== 4'd2 || play_active !== 1'b1) begin failures++; $display("FAIL abort_pre got=%0d/%b exp=2/1", mem_addr, play_active); end
    press(1'b0, 1'b1);
    checks++; if (play_active !== 1'b0 || mem_addr !== 4'd0) begin failures++; $display("FAIL abort_idle got=%b/%0d exp=0/0", play_active, mem_addr); end
    checks++; if (rec_len !== 5'd5) begin failures++; $display("FAIL abort_len got=%0d exp=5", rec_len); end
  endtask

  task automatic test_reset_mid_record;
    int n;
    press(1'b1, 1'b0);
    repeat (3) cyc(1'b0, 1'b0, 1'b1);
    checks++; if (mem_addr !== 4'd3) begin failures++; $display("FAIL rstrec_pre got=%0d exp=3", mem_addr); end
    n = dut_wq.size();
    reset = 1'b0; rec_btn = 1'b0; play_btn = 1'b0; sample_tick = 1'b1;
    #1;
    checks++; if (mem_we !== 1'b0) begin failures++; $display("FAIL rstrec_we got=%b exp=0", mem_we); end
    cyc(1'b0, 1'b0, 1'b1);
    reset = 1'b1;
    checks++; if (rec_active !== 1'b0 || rec_len !== 5'd0 || mem_addr !== 4'd0) begin failures++; $display("FAIL rstrec_post got=%b/%0d/%0d exp=0/0/0", rec_active, rec_len, mem_addr); end
    checks++; if (dut_wq.size() !== n) begin failures++; $display("FAIL rstrec_writes got=%0d exp=%0d", dut_wq.size(), n); end
  endtask

  task automatic test_random;
    int op;
    dut_wq.delete();
    mdl_wq.delete();
    for (int it = 0; it < 60; it++) begin
      op = $urandom_range(0, 6);
      case (op)
        0: begin for (int i = 0; i < DB; i++) cyc(1'b1, 1'b0, $urandom_range(0, 1) == 1); cyc(1'b0, 1'b0, 1'b0); end
        1: begin for (int i = 0; i < DB; i++) cyc(1'b0, 1'b1, $urandom_range(0, 1) == 1); cyc(1'b0, 1'b0, 1'b0); end
        2: ticks($urandom_range(1, 20));
        3: begin repeat ($urandom_range(1, DB - 1)) cyc(1'b1, 1'b1, $urandom_range(0, 1) == 1); cyc(1'b0, 1'b0, 1'b1); end
        4: press(1'b1, 1'b1);
        5: begin
             if ($urandom_range(0, 3) == 0) begin
               reset = 1'b0; cyc($urandom_range(0, 1) == 1, 1'b0, $urandom_range(0, 1) == 1); reset = 1'b1;
             end
           end
        default: repeat ($urandom_range(1, 30)) cyc(1'b0, 1'b0, $urandom_range(0, 3) == 0);
      endcase
      checks++;
      if (rec_len !== (AW+1)'(m_len) || mem_addr !== AW'(m_addr)) begin
        failures++; $display("FAIL rand_state[%0d] got=%0d/%0d exp=%0d/%0d", it, rec_len, mem_addr, m_len, m_addr);
      end
    end
    checks++; if (dut_wq.size() !== mdl_wq.size()) begin failures++; $display("FAIL rand_writes got=%0d exp=%0d", dut_wq.size(), mdl_wq.size()); end
    for (int i = 0; i < mdl_wq.size(); i++) begin
      checks++;
      if (i >= dut_wq.size() || dut_wq[i] != mdl_wq[i]) begin
        failures++; $display("FAIL rand_waddr[%0d] got=%0d exp=%0d", i, (i < dut_wq.size()) ? dut_wq[i] : -1, mdl_wq[i]);
      end
    end
    checks++; if (mon_err !== 0) begin failures++; $display("FAIL monitor_cycles got=%0d exp=0", mon_err); end
  endtask

  initial begin
    reset = 1'b0; rec_btn = 1'b0; play_btn = 1'b0; sample_tick = 1'b0;
    @(posedge clock);
    #1;
    test_reset;
    test_bounce;
    test_record;
    test_full;
    test_play;
    test_simultaneous;
    test_reset_mid_record;
    test_random;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/audio_rec_ctrl.md
AUDIO_REC_CTRL -- requirements
Module: audio_rec_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 16: sample-memory address width.
REQ-002 SHALL have parameter DB_CYCLES, default 100000: consecutive stable-high clocks required to accept a button press.
REQ-003 SHALL have port clock, input, 1: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1: synchronous, active-low reset.
REQ-005 SHALL have port rec_btn, input, 1: record button, already synchronized to clock; debounced here.
REQ-006 SHALL have port play_btn, input, 1: play button, already synchronized to clock; debounced here.
REQ-007 SHALL have port sample_tick, input, 1: one-cycle strobe at the audio sample rate.
REQ-008 SHALL have port mem_addr, output, ADDR_W: current sample-memory address.
REQ-009 SHALL have port mem_we, output, 1: sample-memory write enable.
REQ-010 SHALL have port play_en, output, 1: enables the audio output stage.
REQ-011 SHALL have port rec_active, output, 1: high while in RECORD.
REQ-012 SHALL have port play_active, output, 1: high while in PLAY.
REQ-013 SHALL have port rec_len, output, ADDR_W+1: number of samples in the last recording.

Function
REQ-014 Debounce: a press SHALL be accepted after the button has been high for DB_CYCLES consecutive clocks; any low sample restarts the count.
REQ-015 Each accepted press SHALL produce exactly one single-cycle internal pulse (rec_press / play_press); holding the button SHALL NOT produce further pulses until it has gone low and been accepted again.
REQ-016 The FSM SHALL have the states IDLE, RECORD and PLAY.
REQ-017 IDLE, rec_press: go to RECORD next cycle; mem_addr <= 0; rec_len <= 0.
REQ-018 IDLE, play_press with rec_len != 0: go to PLAY; mem_addr <= 0. With rec_len == 0, play_press SHALL be ignored.
REQ-019 IDLE, rec_press and play_press in the same cycle: record SHALL win.
REQ-020 mem_we SHALL be combinational: (state == RECORD) AND sample_tick. The write uses the mem_addr present in that cycle.
REQ-021 RECORD, each sample_tick: mem_addr increments by 1 next cycle; rec_len increments by 1.
REQ-022 RECORD, sample_tick while mem_addr == 2^ADDR_W-1: the write occurs, rec_len becomes 2^ADDR_W, FSM goes to IDLE, mem_addr <= 0. No wrap-around write SHALL occur.
REQ-023 RECORD, rec_press: go to IDLE, mem_addr <= 0. A sample_tick in the same cycle SHALL still be written and counted.
REQ-024 RECORD: play_press SHALL be ignored.
REQ-025 PLAY: play_en = 1. Each sample_tick increments mem_addr.
REQ-026 PLAY, sample_tick with mem_addr == rec_len-1: go to IDLE, mem_addr <= 0.
REQ-027 PLAY, play_press: abort to IDLE, mem_addr <= 0.
REQ-028 PLAY: rec_press SHALL be ignored.
REQ-029 In PLAY, mem_we SHALL be 0 at all times.
REQ-030 rec_len SHALL be preserved across PLAY and IDLE; it is cleared only on entry to RECORD or on reset.

Reset
REQ-031 With reset low at a clock edge, the block SHALL enter IDLE and clear all of: mem_addr, rec_len, both debounce counters, and both press-detect flags.
REQ-032 During reset: mem_we, play_en, rec_active and play_active = 0.
REQ-033 Reset asserted mid-RECORD or mid-PLAY SHALL abort the operation immediately. No write SHALL occur in a reset cycle, even with sample_tick high.

Structure
REQ-034 Package audio_ctrl_pkg SHALL hold the state enum typedef (IDLE, RECORD, PLAY) and the default values of ADDR_W and DB_CYCLES.
REQ-035 Debounce plus press-pulse logic SHALL be the sub-module button_debounce, instantiated once per button.
REQ-036 The counter width in button_debounce SHALL be $clog2(DB_CYCLES+1).

Verification (bench parameters: ADDR_W=4, DB_CYCLES=4)
REQ-037 Bounce: rec_btn high 3 clocks, low 1, high 4 -> exactly one rec_press, on the 4th clock of the second high run; 20-clock hold -> still one pulse.
REQ-038 Record then stop: record press, 5 sample_ticks, record press -> mem_we pulses at addresses 0..4, rec_len = 5, IDLE, mem_addr = 0.
REQ-039 Full memory: record with 16 ticks -> 16 writes at addresses 0..15, rec_len = 16, automatic IDLE, no write at address 0 afterwards.
REQ-040 Playback: with rec_len = 5, play press -> play_en high, addresses 0..4 stepped on ticks, IDLE after the 5th tick; play press with rec_len = 0 -> stays in IDLE.
REQ-041 Simultaneous/abort: rec and play accepted in the same cycle -> RECORD; play press mid-PLAY at address 2 -> IDLE, mem_addr = 0, rec_len unchanged.
REQ-042 Reset mid-RECORD at address 3 with sample_tick high -> mem_we = 0, IDLE, rec_len = 0, mem_addr = 0.
